// File: rtl/shared_fifo_token_arbiter_pkg.sv
// rtl/shared_fifo_token_arbiter_pkg.sv - shared types and constants for the token arbiter
// Purpose: default sizing, index/occupancy typedefs and the round-robin reset value.
// Ports: none (package).
package shared_fifo_token_arbiter_pkg;

    localparam int N_REQ        = 4;
    localparam int IDX_WIDTH    = 2;
    localparam int P1DEPTH      = 8;
    localparam int P2CNTR_WIDTH = 4;
    localparam int MAX_PER_REQ  = 4;

    typedef logic [IDX_WIDTH-1:0]    req_idx_t;
    typedef logic [P2CNTR_WIDTH-1:0] occ_cnt_t;

    localparam req_idx_t RESET_RR_PTR = '0;

endpackage

// File: rtl/shared_fifo_token_arbiter_rr_priority_pick.sv
// rtl/shared_fifo_token_arbiter_rr_priority_pick.sv - combinational rotating-priority picker
// Purpose: pick the first eligible index at or above the rr pointer, wrapping modulo n_req.
// Ports: i_elig (eligible vector), i_rr_ptr (start index),
//        o_grant (one-hot winner), o_idx (winner index), o_valid (any eligible).
module rr_priority_pick #(
    parameter int n_req     = 4,
    parameter int idx_width = 2
) (
    input  logic [n_req-1:0]     i_elig,
    input  logic [idx_width-1:0] i_rr_ptr,
    output logic [n_req-1:0]     o_grant,
    output logic [idx_width-1:0] o_idx,
    output logic                 o_valid
);

    logic [2*n_req-1:0]   w_dbl;
    logic [n_req-1:0]     w_rot;
    logic [idx_width-1:0] w_off;
    logic [idx_width:0]   w_sum;

    // Rotating the doubled vector puts the rr pointer's requester at bit 0,
    // so a plain lowest-set-bit search gives the round-robin winner.
    assign w_dbl = {i_elig, i_elig} >> i_rr_ptr;
    assign w_rot = w_dbl[n_req-1:0];

    always_comb begin
        o_valid = 1'b0;
        w_off   = '0;
        // Descending scan: the last hit written is the lowest offset.
        for (int k = n_req - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_valid = 1'b1;
                w_off   = idx_width'(k);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, i_rr_ptr} + {1'b0, w_off};
        if (w_sum >= (idx_width+1)'(n_req)) begin
            w_sum = w_sum - (idx_width+1)'(n_req);
        end
        o_idx   = w_sum[idx_width-1:0];
        o_grant = o_valid ? (n_req'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/shared_fifo_token_arbiter.sv
// rtl/shared_fifo_token_arbiter.sv - shared occupancy FIFO with round-robin token grant
// Purpose: n_req requesters share a data-less FIFO; each grant enqueues the owner index,
//          each dequeue reports and frees the head owner; per-requester cap max_per_req.
// Ports: CLK, RST (sync active-high), CLR (sync flush), REQ[n_req] requests,
//        GRANT[n_req] one-hot grant, GRANT_IDX winner index, DEQ consumer pop,
//        DEQ_IDX head owner, EMPTY_N, FULL_N, COUNT occupancy.
module shared_fifo_token_arbiter
    import shared_fifo_token_arbiter_pkg::*;
#(
    parameter int n_req        = N_REQ,
    parameter int idx_width    = IDX_WIDTH,
    parameter int p1depth      = P1DEPTH,
    parameter int p2cntr_width = P2CNTR_WIDTH,
    parameter int max_per_req  = MAX_PER_REQ
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CLR,
    input  logic [n_req-1:0]        REQ,
    output logic [n_req-1:0]        GRANT,
    output logic [idx_width-1:0]    GRANT_IDX,
    input  logic                    DEQ,
    output logic [idx_width-1:0]    DEQ_IDX,
    output logic                    EMPTY_N,
    output logic                    FULL_N,
    output logic [p2cntr_width-1:0] COUNT
);

    localparam int ptr_width = (p1depth > 2) ? $clog2(p1depth) : 1;

    logic [idx_width-1:0]    r_rr_ptr;
    logic [p2cntr_width-1:0] r_own_cnt [n_req];
    logic [idx_width-1:0]    r_queue   [p1depth];
    logic [ptr_width-1:0]    r_head;
    logic [ptr_width-1:0]    r_tail;
    logic [p2cntr_width-1:0] r_count;
    logic                    r_empty_n;
    logic                    r_full_n;

    logic [n_req-1:0]        w_elig;
    logic [n_req-1:0]        w_pick_onehot;
    logic [idx_width-1:0]    w_pick_idx;
    logic                    w_pick_valid;
    logic                    w_grant_en;
    logic                    w_deq_en;

    always_comb begin
        for (int i = 0; i < n_req; i++) begin
            w_elig[i] = REQ[i] && (r_own_cnt[i] < p2cntr_width'(max_per_req));
        end
    end

    rr_priority_pick #(
        .n_req     (n_req),
        .idx_width (idx_width)
    ) u_pick (
        .i_elig   (w_elig),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // Grant ignores DEQ on purpose: a full queue never grants, keeping the
    // grant path free of the consumer timing.
    assign w_grant_en = w_pick_valid && r_full_n && !CLR && !RST;
    assign w_deq_en   = DEQ && r_empty_n && !CLR && !RST;

    assign GRANT     = w_grant_en ? w_pick_onehot : '0;
    assign GRANT_IDX = w_pick_idx;
    assign DEQ_IDX   = r_queue[r_head];
    assign EMPTY_N   = r_empty_n;
    assign FULL_N    = r_full_n;
    assign COUNT     = r_count;

    // Queue contents are deliberately not cleared by reset or flush.
    always_ff @(posedge CLK) begin
        if (w_grant_en) begin
            r_queue[r_tail] <= w_pick_idx;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            r_rr_ptr  <= idx_width'(RESET_RR_PTR);
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_empty_n <= 1'b0;
            r_full_n  <= 1'b1;
            for (int i = 0; i < n_req; i++) begin
                r_own_cnt[i] <= '0;
            end
        end else begin
            if (w_grant_en) begin
                r_tail   <= (r_tail == ptr_width'(p1depth - 1)) ? '0 : r_tail + 1'b1;
                r_rr_ptr <= (w_pick_idx == idx_width'(n_req - 1)) ? '0 : w_pick_idx + 1'b1;
            end
            if (w_deq_en) begin
                r_head <= (r_head == ptr_width'(p1depth - 1)) ? '0 : r_head + 1'b1;
            end
            // A grant and a dequeue for the same owner cancel out.
            for (int i = 0; i < n_req; i++) begin
                if (w_grant_en && (w_pick_idx == idx_width'(i)) &&
                    !(w_deq_en && (DEQ_IDX == idx_width'(i)))) begin
                    r_own_cnt[i] <= r_own_cnt[i] + 1'b1;
                end else if (w_deq_en && (DEQ_IDX == idx_width'(i)) &&
                             !(w_grant_en && (w_pick_idx == idx_width'(i)))) begin
                    r_own_cnt[i] <= r_own_cnt[i] - 1'b1;
                end
            end
            case ({w_grant_en, w_deq_en})
                2'b10: begin
                    r_count   <= r_count + 1'b1;
                    r_empty_n <= 1'b1;
                    r_full_n  <= (r_count != p2cntr_width'(p1depth - 1));
                end
                2'b01: begin
                    r_count   <= r_count - 1'b1;
                    r_full_n  <= 1'b1;
                    r_empty_n <= (r_count != p2cntr_width'(1));
                end
                default: begin
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (!RST && DEQ && !r_empty_n) begin
            $display("WARNING: %m DEQ while empty ignored at %0t", $time);
        end
    end
`endif

endmodule

// File: tb/tb_shared_fifo_token_arbiter.sv
// tb/tb_shared_fifo_token_arbiter.sv - self-checking bench for shared_fifo_token_arbiter
module tb_shared_fifo_token_arbiter;

    localparam int NR    = 4;
    localparam int DEPTH = 8;
    localparam int CAP   = 4;

    logic       CLK;
    logic       RST;
    logic       CLR;
    logic [3:0] REQ;
    logic [3:0] GRANT;
    logic [1:0] GRANT_IDX;
    logic       DEQ;
    logic [1:0] DEQ_IDX;
    logic       EMPTY_N;
    logic       FULL_N;
    logic [3:0] COUNT;

    int n_checks = 0;
    int n_pass   = 0;

    int q[$];
    int rr = 0;

    shared_fifo_token_arbiter dut (
        .CLK       (CLK),
        .RST       (RST),
        .CLR       (CLR),
        .REQ       (REQ),
        .GRANT     (GRANT),
        .GRANT_IDX (GRANT_IDX),
        .DEQ       (DEQ),
        .DEQ_IDX   (DEQ_IDX),
        .EMPTY_N   (EMPTY_N),
        .FULL_N    (FULL_N),
        .COUNT     (COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int owned(input int r);
        int c = 0;
        foreach (q[k]) if (q[k] == r) c++;
        return c;
    endfunction

    function automatic int pick(input logic [3:0] req);
        for (int k = 0; k < NR; k++) begin
            int j = (rr + k) % NR;
            if (req[j] && owned(j) < CAP) return j;
        end
        return -1;
    endfunction

    task automatic step(input logic [3:0] req, input logic deq, input logic clr, input logic rst);
        int w;
        bit d;
        REQ = req; DEQ = deq; CLR = clr; RST = rst;
        #1;
        w = (!rst && !clr && q.size() < DEPTH) ? pick(req) : -1;
        d = !rst && !clr && deq && q.size() > 0;
        chk("grant", GRANT, (w < 0) ? 0 : (1 << w));
        if (w >= 0) chk("grant_idx", GRANT_IDX, w);
        chk("count", COUNT, q.size());
        chk("empty_n", EMPTY_N, q.size() > 0);
        chk("full_n", FULL_N, q.size() < DEPTH);
        if (q.size() > 0) chk("deq_idx", DEQ_IDX, q[0]);
        if (rst || clr) begin
            q.delete();
            rr = 0;
        end else begin
            if (d) void'(q.pop_front());
            if (w >= 0) begin
                q.push_back(w);
                rr = (w + 1) % NR;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        REQ = '0; DEQ = 0; CLR = 0; RST = 1;
        repeat (2) @(posedge CLK);
        #1;
        step(4'h0, 0, 0, 0);

        // Fill from all four requesters until full; grants rotate 0,1,2,3.
        repeat (10) step(4'hF, 0, 0, 0);
        chk("fill_count", COUNT, 8);
        // One dequeue from full, then the next grant lands on requester 0.
        step(4'hF, 1, 0, 0);
        repeat (2) step(4'hF, 0, 0, 0);

        // Single requester stops at the per-requester cap.
        step(4'h0, 0, 0, 1);
        repeat (6) step(4'h1, 0, 0, 0);
        chk("cap_count", COUNT, 4);
        step(4'h1, 1, 0, 0);
        repeat (2) step(4'h1, 0, 0, 0);

        // Simultaneous grant and dequeue at occupancy 3.
        step(4'h0, 0, 0, 1);
        repeat (3) step(4'hF, 0, 0, 0);
        step(4'hF, 1, 0, 0);
        step(4'h0, 0, 0, 0);
        chk("simul_count", COUNT, 3);

        // Dequeue while empty is ignored.
        step(4'h0, 0, 0, 1);
        step(4'h0, 1, 0, 0);
        step(4'h0, 0, 0, 0);

        // Flush and reset at occupancy 5 with all requesting.
        repeat (5) step(4'hF, 0, 0, 0);
        step(4'hF, 0, 1, 0);
        step(4'hF, 0, 0, 0);
        repeat (4) step(4'hF, 0, 0, 0);
        step(4'hF, 0, 0, 1);
        step(4'hF, 0, 0, 0);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 500; n++) begin
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 59) == 0, $urandom_range(0, 99) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
